main_control_fsm: RTL
=====================

// Module: main_control_fsm
// PURPOSE
//  Multicycle main control unit: Moore FSM decoding the 6-bit opcode into per-cycle datapath
//  enables and the 2-bit ALUOp consumed by the ALU control decoder (00=add, 01=sub, 10=funct).
//  Sits between instruction register and datapath; sequences fetch/decode/execute/mem/writeback.
//  Stalls on memory via mem_ready.
// PARAMETERS
//  OP_W      6   opcode width (instr[31:26])
//  STATE_W   4   state register width
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  opcode         in   OP_W     IR opcode field, valid from DECODE onward
//  mem_ready      in   1        memory access completes this cycle
//  pc_write       out  1        unconditional PC load
//  pc_write_cond  out  1        PC load if ALU zero (beq)
//  iord           out  1        0=PC addresses memory, 1=ALUOut
//  mem_read       out  1        memory read request
//  mem_write      out  1        memory write request
//  ir_write       out  1        IR load
//  mem_to_reg     out  1        1=MDR to regfile, 0=ALUOut
//  reg_dst        out  1        1=rd, 0=rt
//  reg_write      out  1        regfile write enable
//  alu_src_a      out  1        0=PC, 1=A
//  alu_src_b      out  2        00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//  alu_op         out  2        ALUOp to ALU control
//  pc_source      out  2        00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1        1-cycle pulse, unrecognised opcode in DECODE
//  instr_done     out  1        1-cycle pulse in final state of each instruction
//  state_o        out  STATE_W  current state (debug)
// BEHAVIOUR
//  - Moore outputs decoded from state only (plus mem_ready gating below); unlisted outputs 0.
//  - rst_n low (any time, mid-instruction incl.): state=IDLE at once; all outputs 0.
//    IDLE -> FETCH on first clk after release.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//    ir_write=pc_write=mem_ready; stay while !mem_ready, else -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
//    100011 lw/101011 sw -> MEMADR; 000000 R -> EXEC; 000100 beq -> BRANCH; 000010 j -> JUMP;
//    001000 addi -> ADDI_EX (only if MC_ADDI_EN); other -> FETCH with illegal_op=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMRD (lw) / MEMWR (sw).
//  - MEMRD: mem_read=1, iord=1; hold until mem_ready -> MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
//  - MEMWR: mem_write=1, iord=1; hold until mem_ready; instr_done=mem_ready -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
//  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01,
//    instr_done=1 -> FETCH.
//  - JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
//  - Cycles per instr with mem_ready tied 1: lw 5, sw 4, R 4, beq 3, j 3, addi 4.
//  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; outputs held constant.
//  - Unreachable state encodings -> IDLE on next clk.
// CONFIGURATION
//  - MC_ADDI_EN defined: ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDI_WB
//    (reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1) -> FETCH.
//  - Undefined: opcode 001000 treated as illegal (illegal_op pulse, -> FETCH); states absent.
// STRUCTURE
//  - Shared package mc_pkg: opcode constants, ALUOp localparams (ADD/SUB/FUNCT),
//    alu_src_b and pc_source encodings, state encodings.
//  - Single module; no sub-module: next-state block + output-decode block.
// TESTING
//  - Reset: rst_n=0 -> all outputs 0, state_o=IDLE; release -> FETCH next clk, mem_read=1.
//  - lw (100011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write+mem_to_reg in 5th.
//  - R-type (000000) -> alu_op=10 in EXEC; reg_dst=1, reg_write=1 next cycle; instr_done once.
//  - beq (000100) -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01; j -> pc_source=10.
//  - mem_ready=0 for 3 cycles in FETCH -> ir_write/pc_write 0, state held; asserted on 4th.
//  - opcode 111111 -> illegal_op pulse in DECODE, back to FETCH; 001000 per MC_ADDI_EN;
//    rst_n low in MEMRD -> IDLE immediately, mem_read drops to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, ALUOp,
// ALU-B / PC-source mux selects and state codes.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RWB     = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_EX = 4'd11,
      S_ADDI_WB = 4'd12
   } state_e;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control: Moore FSM sequencing fetch/decode/execute/mem/wb.
// Define MC_ADDI_EN to add the addi path (ADDI_EX/ADDI_WB); otherwise addi is illegal.
module main_control_fsm
   import mc_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               illegal_op,
   output logic               instr_done,
   output logic [STATE_W-1:0] state_o
);

   state_e state, nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_IDLE:   nxt = S_FETCH;
         S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
`ifdef MC_ADDI_EN
               OP_ADDI:      nxt = S_ADDI_EX;
`endif
               default:      nxt = S_FETCH;
            endcase
         end
         S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  nxt = S_FETCH;
         S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt = S_RWB;
         S_RWB:    nxt = S_FETCH;
         S_BRANCH: nxt = S_FETCH;
         S_JUMP:   nxt = S_FETCH;
`ifdef MC_ADDI_EN
         S_ADDI_EX: nxt = S_ADDI_WB;
         S_ADDI_WB: nxt = S_FETCH;
`endif
         default:  nxt = S_IDLE;
      endcase
   end

   // Outputs follow the state register (async reset forces IDLE, so all-zero at once);
   // only the memory handshakes look at mem_ready.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = SRCB_IMMSH;
            illegal_op = (nxt == S_FETCH);
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
         end
`ifdef MC_ADDI_EN
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign state_o = STATE_W'(state);

endmodule
